// File: rtl/pl_scrambler_pkg.sv
// Shared constants and helpers for the PL scrambler: Gold generator seeds,
// tap positions, the Rn rotation encoding and a one-step generator advance.
package pl_scrambler_pkg;

  localparam logic [17:0] X_SEED = 18'h00001;
  localparam logic [17:0] Y_SEED = 18'h3FFFF;

  // Feedback taps (bit 0 is always part of the feedback)
  localparam int X_FB_TAP   = 7;
  localparam int Y_FB_TAP_A = 10;
  localparam int Y_FB_TAP_B = 7;
  localparam int Y_FB_TAP_C = 5;

  // z1 taps: x bits 4,6,15 and y bits 5,6,8..15
  localparam logic [17:0] Z1_X_MASK = 18'h08050;
  localparam logic [17:0] Z1_Y_MASK = 18'h0FF60;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,  // ( I,  Q)
    ROT_90  = 2'd1,  // (-Q,  I)
    ROT_180 = 2'd2,  // (-I, -Q)
    ROT_270 = 2'd3   // ( Q, -I)
  } rn_e;

  typedef struct packed {
    logic [17:0] x;
    logic [17:0] y;
  } gold_t;

  // Advance both LFSRs by one symbol
  function automatic gold_t gold_step(input gold_t g);
    gold_t n;
    n.x = {g.x[X_FB_TAP] ^ g.x[0], g.x[17:1]};
    n.y = {g.y[Y_FB_TAP_A] ^ g.y[Y_FB_TAP_B] ^ g.y[Y_FB_TAP_C] ^ g.y[0], g.y[17:1]};
    return n;
  endfunction

  // Rn = {z1, z0} for the symbol using generator state g
  function automatic logic [1:0] gold_rn(input gold_t g);
    logic z0;
    logic z1;
    z0 = g.x[0] ^ g.y[0];
    z1 = (^(g.x & Z1_X_MASK)) ^ (^(g.y & Z1_Y_MASK));
    return {z1, z0};
  endfunction

endpackage

// File: rtl/pl_rotate.sv
// Combinational quarter-turn rotation of one complex symbol by Rn.
// Negation saturates so the most negative code maps to the most positive.
module pl_rotate
  import pl_scrambler_pkg::*;
#(
  parameter int SYM_W = 8
) (
  input  logic [SYM_W-1:0] sym_i,
  input  logic [SYM_W-1:0] sym_q,
  input  logic [1:0]       rn,
  output logic [SYM_W-1:0] rot_i,
  output logic [SYM_W-1:0] rot_q
);

  localparam logic [SYM_W-1:0] S_MIN = {1'b1, {(SYM_W-1){1'b0}}};
  localparam logic [SYM_W-1:0] S_MAX = {1'b0, {(SYM_W-1){1'b1}}};

  logic [SYM_W-1:0] neg_i;
  logic [SYM_W-1:0] neg_q;

  assign neg_i = (sym_i == S_MIN) ? S_MAX : -sym_i;
  assign neg_q = (sym_q == S_MIN) ? S_MAX : -sym_q;

  // select the rotated pair
  always_comb begin
    rot_i = sym_i;
    rot_q = sym_q;
    case (rn_e'(rn))
      ROT_0:   begin rot_i = sym_i; rot_q = sym_q; end
      ROT_90:  begin rot_i = neg_q; rot_q = sym_i; end
      ROT_180: begin rot_i = neg_i; rot_q = neg_q; end
      ROT_270: begin rot_i = sym_q; rot_q = neg_i; end
      default: begin rot_i = sym_i; rot_q = sym_q; end
    endcase
  end

endmodule

// File: rtl/pl_scrambler.sv
// Physical-layer scrambler: Gold-sequence Rn per symbol, LANES symbols per
// beat, one-cycle registered output with a ready/valid skid-free handshake.
module pl_scrambler
  import pl_scrambler_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int SYM_W     = 8,
  parameter int FRAME_LEN = 90
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [17:0]            i_x_init,
  input  logic                   i_bypass,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_sof,
  input  logic [LANES*SYM_W-1:0] i_i,
  input  logic [LANES*SYM_W-1:0] i_q,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*SYM_W-1:0] o_i,
  output logic [LANES*SYM_W-1:0] o_q,
  output logic [2*LANES-1:0]     o_rn,
  output logic                   o_sof,
  output logic                   o_sof_err
);

  localparam int               CNT_W   = 17;
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME_LEN);

  gold_t                          gen_q;
  gold_t [LANES:0]                gold;
  logic  [CNT_W-1:0]              cnt_q;
  logic  [CNT_W-1:0]              cnt_inc;
  logic  [CNT_W-1:0]              cnt_nxt;
  logic                           accept;
  logic                           frame_start;
  logic                           sof_err;
  logic  [LANES-1:0][1:0]         lane_rn;
  logic  [LANES-1:0][SYM_W-1:0]   lane_i;
  logic  [LANES-1:0][SYM_W-1:0]   lane_q;
  logic  [LANES-1:0][SYM_W-1:0]   rot_i;
  logic  [LANES-1:0][SYM_W-1:0]   rot_q;

  assign o_ready = i_ready | ~o_valid;
  assign accept  = i_valid & o_ready;

  // A counter value of 0 means the next symbol opens a frame; an explicit
  // i_sof mid-frame restarts the frame and is flagged.
  assign frame_start = i_sof | (cnt_q == '0);
  assign sof_err     = accept & i_sof & (cnt_q != '0);

  assign cnt_inc = (frame_start ? '0 : cnt_q) + LANES_C;
  assign cnt_nxt = (cnt_inc >= FRAME_C) ? '0 : cnt_inc;

  assign gold[0] = frame_start ? gold_t'{x: i_x_init, y: Y_SEED} : gen_q;
  assign lane_i  = i_i;
  assign lane_q  = i_q;

  // Lane k sees the generator k steps after the beat's start state
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign gold[k+1]  = gold_step(gold[k]);
    assign lane_rn[k] = i_bypass ? 2'b00 : gold_rn(gold[k]);

    pl_rotate #(.SYM_W(SYM_W)) u_rot (
      .sym_i (lane_i[k]),
      .sym_q (lane_q[k]),
      .rn    (lane_rn[k]),
      .rot_i (rot_i[k]),
      .rot_q (rot_q[k])
    );
  end

  // generator and symbol counter advance only on accepted beats
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gen_q <= gold_t'{x: X_SEED, y: Y_SEED};
      cnt_q <= '0;
    end else if (accept) begin
      gen_q <= gold[LANES];
      cnt_q <= cnt_nxt;
    end
  end

  // output register; holds its beat while downstream stalls
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_sof     <= 1'b0;
      o_sof_err <= 1'b0;
      o_i       <= '0;
      o_q       <= '0;
      o_rn      <= '0;
    end else begin
      o_sof_err <= sof_err;
      if (o_ready) begin
        o_valid <= i_valid;
        if (i_valid) begin
          o_i   <= rot_i;
          o_q   <= rot_q;
          o_rn  <= lane_rn;
          o_sof <= frame_start;
        end
      end
    end
  end

endmodule

// File: tb/tb_pl_scrambler.sv
// Directed bench for pl_scrambler: one LANES=1/FRAME_LEN=90 instance and one
// LANES=4/FRAME_LEN=8 instance sharing clock and reset.
module tb_pl_scrambler;

  // Rn for symbols 0..7 of a frame with x_init = 1 (hand-derived)
  localparam int RN_TAB [8] = '{0, 1, 1, 1, 1, 3, 1, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [17:0] xi1 = 18'd1;
  logic        byp1 = 1'b0, v1 = 1'b0, sof1 = 1'b0, rdy1 = 1'b1;
  logic [7:0]  i1 = '0, q1 = '0;
  logic        o_ready_1, o_valid_1, o_sof_1, o_sof_err_1;
  logic [7:0]  o_i_1, o_q_1;
  logic [1:0]  o_rn_1;

  logic [17:0] xi4 = 18'd1;
  logic        byp4 = 1'b0, v4 = 1'b0, sof4 = 1'b0, rdy4 = 1'b1;
  logic [31:0] i4 = '0, q4 = '0;
  logic        o_ready_4, o_valid_4, o_sof_4, o_sof_err_4;
  logic [31:0] o_i_4, o_q_4;
  logic [7:0]  o_rn_4;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pl_scrambler #(.LANES(1), .SYM_W(8), .FRAME_LEN(90)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_x_init(xi1), .i_bypass(byp1),
    .i_valid(v1), .o_ready(o_ready_1), .i_sof(sof1), .i_i(i1), .i_q(q1),
    .o_valid(o_valid_1), .i_ready(rdy1), .o_i(o_i_1), .o_q(o_q_1),
    .o_rn(o_rn_1), .o_sof(o_sof_1), .o_sof_err(o_sof_err_1)
  );

  pl_scrambler #(.LANES(4), .SYM_W(8), .FRAME_LEN(8)) u_dut4 (
    .i_clk(clk), .i_reset(rst), .i_x_init(xi4), .i_bypass(byp4),
    .i_valid(v4), .o_ready(o_ready_4), .i_sof(sof4), .i_i(i4), .i_q(q4),
    .o_valid(o_valid_4), .i_ready(rdy4), .o_i(o_i_4), .o_q(o_q_4),
    .o_rn(o_rn_4), .o_sof(o_sof_4), .o_sof_err(o_sof_err_4)
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // one accepted beat on the single-lane instance, sampled 1ns after the edge
  task automatic beat1(input logic sof, input int si, input int sq);
    v1 = 1'b1; sof1 = sof; i1 = 8'(si); q1 = 8'(sq);
    @(posedge clk); #1;
    v1 = 1'b0; sof1 = 1'b0;
  endtask

  initial begin
    int ei4 [4];
    int eq4 [4];
    ei4 = '{10, -2, -3, -4};
    eq4 = '{1, 20, 30, 40};

    // reset state
    #12;
    chk("rst_valid", o_valid_1, 0);
    chk("rst_ready", o_ready_1, 1);
    chk("rst_rn",    o_rn_1, 0);
    chk("rst_i",     o_i_1, 0);
    chk("rst_sof",   o_sof_1, 0);
    chk("rst_err",   o_sof_err_1, 0);
    chk("rst_v4",    o_valid_4, 0);
    @(negedge clk); rst = 1'b0;

    // first frame, x_init = 1
    for (int n = 0; n < 8; n++) begin
      beat1(n == 0, 100, 20);
      chk($sformatf("a_rn%0d", n), o_rn_1, RN_TAB[n]);
      if (n == 0) begin
        chk("a_sof0", o_sof_1, 1);
        chk("a_i0", $signed(o_i_1), 100);
        chk("a_q0", $signed(o_q_1), 20);
      end
      if (n == 1) begin
        chk("a_sof1", o_sof_1, 0);
        chk("a_i1", $signed(o_i_1), -20);
        chk("a_q1", $signed(o_q_1), 100);
      end
      if (n == 2) begin
        chk("a_i2", $signed(o_i_1), -20);
        chk("a_q2", $signed(o_q_1), 100);
      end
      if (n == 5) begin
        chk("a_i5", $signed(o_i_1), 20);
        chk("a_q5", $signed(o_q_1), -100);
      end
    end

    // x_init = 0 with bypass, mid-frame sof flagged
    xi1 = 18'd0; byp1 = 1'b1;
    beat1(1'b1, 55, -66);
    chk("b_rn_byp", o_rn_1, 0);
    chk("b_i_byp", $signed(o_i_1), 55);
    chk("b_q_byp", $signed(o_q_1), -66);
    chk("b_err", o_sof_err_1, 1);
    chk("b_sof", o_sof_1, 1);
    byp1 = 1'b0;
    beat1(1'b0, 1, 2);
    chk("b_rn1", o_rn_1, 1);
    chk("b_err_clr", o_sof_err_1, 0);

    // saturation
    xi1 = 18'h00011;
    beat1(1'b1, -128, 5);
    chk("c_rn", o_rn_1, 2);
    chk("c_i_sat", $signed(o_i_1), 127);
    chk("c_q", $signed(o_q_1), -5);
    beat1(1'b0, 3, -128);
    chk("c_rn1", o_rn_1, 1);
    chk("c_i_sat90", $signed(o_i_1), 127);
    chk("c_q90", $signed(o_q_1), 3);

    // backpressure
    xi1 = 18'd1;
    beat1(1'b1, 11, 22);
    rdy1 = 1'b0; v1 = 1'b1; i1 = 8'd33; q1 = 8'd44;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("d_rdy%0d", c), o_ready_1, 0);
      chk($sformatf("d_hold%0d", c), $signed(o_i_1), 11);
      chk($sformatf("d_vld%0d", c), o_valid_1, 1);
    end
    rdy1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("d_rn_b", o_rn_1, 1);
    chk("d_i_b", $signed(o_i_1), -44);
    chk("d_q_b", $signed(o_q_1), 33);
    @(posedge clk); #1;
    chk("d_drain", o_valid_1, 0);

    // frame wrap at 90 and mid-frame sof at position 45 of the next frame
    for (int n = 0; n <= 137; n++) begin
      beat1((n == 0) || (n == 135), n, 1);
      if (n == 0)   chk("e_sof0", o_sof_1, 1);
      if (n == 89)  chk("e_sof89", o_sof_1, 0);
      if (n == 90) begin
        chk("e_sof90", o_sof_1, 1);
        chk("e_rn90", o_rn_1, 0);
      end
      if (n == 91)  chk("e_rn91", o_rn_1, 1);
      if (n == 134) chk("e_err_pre", o_sof_err_1, 0);
      if (n == 135) begin
        chk("e_err45", o_sof_err_1, 1);
        chk("e_sof45", o_sof_1, 1);
        chk("e_rn45", o_rn_1, 0);
      end
      if (n == 136) begin
        chk("e_err_once", o_sof_err_1, 0);
        chk("e_rn46", o_rn_1, 1);
      end
      if (n == 137) chk("e_rn47", o_rn_1, 1);
    end
    @(posedge clk); #1;

    // reset while a beat is stalled at the output
    rdy1 = 1'b0;
    beat1(1'b0, 9, 9);
    chk("f_vld", o_valid_1, 1);
    rst = 1'b1; #1;
    chk("f_vld_rst", o_valid_1, 0);
    @(negedge clk); rst = 1'b0; rdy1 = 1'b1;
    beat1(1'b0, 7, 9);
    chk("f_rn", o_rn_1, 0);
    chk("f_sof", o_sof_1, 1);
    chk("f_i", $signed(o_i_1), 7);

    // four lanes, FRAME_LEN = 8
    v4 = 1'b1; sof4 = 1'b1;
    i4 = {8'd40, 8'd30, 8'd20, 8'd10};
    q4 = {8'd4, 8'd3, 8'd2, 8'd1};
    @(posedge clk); #1;
    chk("g_rn0", o_rn_4, 8'h54);
    chk("g_sof0", o_sof_4, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("g_i_l%0d", k), $signed(o_i_4[k*8 +: 8]), ei4[k]);
      chk($sformatf("g_q_l%0d", k), $signed(o_q_4[k*8 +: 8]), eq4[k]);
    end
    sof4 = 1'b0;
    @(posedge clk); #1;
    chk("g_rn1", o_rn_4, 8'hDD);
    chk("g_sof1", o_sof_4, 0);
    @(posedge clk); #1;
    v4 = 1'b0;
    chk("g_rn_wrap", o_rn_4, 8'h54);
    chk("g_sof_wrap", o_sof_4, 1);
    chk("g_err", o_sof_err_4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
